mby_tag_uc_ring_arb: RTL and testbench

//  Per-node unicast tag ring insertion arbiter. Shares one mby_tag_ring_t ring slot per

---
 rtl/mby_tag_uc_ring_arb_if.sv | 43 ++++
 rtl/mby_tag_uc_ring_arb.sv | 174 +++++++++++++++++
 tb/tb_mby_tag_uc_ring_arb.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mby_tag_uc_ring_arb_if.sv
// Bundles the ring-slot and local-requester signals of one unicast tag ring stop.
// master drives ring input, requests and config; slave is the arbiter.
interface mby_tag_uc_ring_arb_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32
);
    logic                      cfg_en;
    logic                      ring_in_val;
    logic [DATA_W-1:0]         ring_in_data;
    logic                      ring_in_stall;
    logic [N_REQ-1:0]          req_val;
    logic [N_REQ*DATA_W-1:0]   req_data;
    logic [N_REQ-1:0]          req_rdy;
    logic                      ring_out_val;
    logic [DATA_W-1:0]         ring_out_data;
    logic                      ring_out_dbg;

    modport master (
        output cfg_en,
        output ring_in_val,
        output ring_in_data,
        output req_val,
        output req_data,
        input  ring_in_stall,
        input  req_rdy,
        input  ring_out_val,
        input  ring_out_data,
        input  ring_out_dbg
    );

    modport slave (
        input  cfg_en,
        input  ring_in_val,
        input  ring_in_data,
        input  req_val,
        input  req_data,
        output ring_in_stall,
        output req_rdy,
        output ring_out_val,
        output ring_out_data,
        output ring_out_dbg
    );
endinterface

// File: rtl/mby_tag_uc_ring_arb.sv
// Unicast tag ring insertion arbiter: ring traffic passes through, local requesters share idle
// slots round-robin. Define MBY_TAG_UC_ARB_ANTISTARVE_EN to force an insert after starvation.
module mby_tag_uc_ring_arb #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic                  clk,
    input logic                  rst,
    mby_tag_uc_ring_arb_if.slave io_bus
);
    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W:0] NREQ_W = (PTR_W + 1)'(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || STARVE_LIMIT < 1) begin : g_bad_cfg
        $error("mby_tag_uc_ring_arb: unsupported N_REQ or STARVE_LIMIT");
    end

    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  w_rr_ptr_d;
    logic              r_out_val;
    logic              w_out_val_d;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_out_data_d;
    logic              r_out_dbg;
    logic              w_out_dbg_d;
    logic [N_REQ-1:0]  w_req_rdy;
    logic              w_stall;
    logic              w_grant;
    logic              w_local_ok;
    logic              w_denied;
    logic              w_force;
    logic [PTR_W-1:0]  w_win;
    logic [PTR_W:0]    w_win_nxt;

    assign w_local_ok = ~rst & io_bus.cfg_en & (|io_bus.req_val);
    assign w_denied   = w_local_ok & io_bus.ring_in_val;

    // First asserted request at or after the pointer; scanning downward lets the
    // smallest offset win.
    always_comb begin
        logic [PTR_W:0] idx;
        w_win = r_rr_ptr;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, r_rr_ptr} + (PTR_W + 1)'(k);
            if (idx >= NREQ_W) begin
                idx = idx - NREQ_W;
            end
            if (io_bus.req_val[idx[PTR_W-1:0]]) begin
                w_win = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_win_nxt = {1'b0, w_win} + (PTR_W + 1)'(1);
        if (w_win_nxt == NREQ_W) begin
            w_win_nxt = '0;
        end
    end

`ifdef MBY_TAG_UC_ARB_ANTISTARVE_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StPass,
        StStarving,
        StForce
    } arb_state_e;

    arb_state_e       r_state;
    arb_state_e       w_state_d;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_d;
    logic [CNT_W-1:0] w_wait_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StPass;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_wait_cnt_d = r_wait_cnt;
        w_wait_inc   = (r_wait_cnt == LIMIT_C) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
        case (r_state)
            StPass: begin
                if (w_denied) begin
                    w_wait_cnt_d = CNT_W'(1);
                    w_state_d    = (LIMIT_C == CNT_W'(1)) ? StForce : StStarving;
                end
            end
            StStarving: begin
                if (w_denied) begin
                    w_wait_cnt_d = w_wait_inc;
                    if (w_wait_inc == LIMIT_C) begin
                        w_state_d = StForce;
                    end
                end else begin
                    // Natural grant, requests withdrawn or insertion disabled.
                    w_wait_cnt_d = '0;
                    w_state_d    = StPass;
                end
            end
            StForce: begin
                w_wait_cnt_d = '0;
                w_state_d    = StPass;
            end
            default: begin
                w_wait_cnt_d = '0;
                w_state_d    = StPass;
            end
        endcase
    end

    assign w_force = (r_state == StForce) & ~rst;
`else
    assign w_force = 1'b0;
`endif

    always_comb begin
        w_req_rdy    = '0;
        w_stall      = 1'b0;
        w_grant      = 1'b0;
        w_out_val_d  = 1'b0;
        w_out_data_d = r_out_data;
        w_out_dbg_d  = 1'b0;
        w_rr_ptr_d   = r_rr_ptr;
        if (w_force) begin
            // Upstream holds its slot; the local winner takes this cycle.
            w_stall = 1'b1;
            w_grant = w_local_ok;
        end else if (io_bus.ring_in_val && !rst) begin
            w_out_val_d  = 1'b1;
            w_out_data_d = io_bus.ring_in_data;
        end else begin
            w_grant = w_local_ok;
        end
        if (w_grant) begin
            w_req_rdy[w_win] = 1'b1;
            w_out_val_d      = 1'b1;
            w_out_data_d     = io_bus.req_data[w_win*DATA_W +: DATA_W];
            w_out_dbg_d      = 1'b1;
            w_rr_ptr_d       = w_win_nxt[PTR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_out_val  <= 1'b0;
            r_out_data <= '0;
            r_out_dbg  <= 1'b0;
        end else begin
            r_rr_ptr   <= w_rr_ptr_d;
            r_out_val  <= w_out_val_d;
            r_out_data <= w_out_data_d;
            r_out_dbg  <= w_out_dbg_d;
        end
    end

    assign io_bus.req_rdy       = w_req_rdy;
    assign io_bus.ring_in_stall = w_stall;
    assign io_bus.ring_out_val  = r_out_val;
    assign io_bus.ring_out_data = r_out_data;
    assign io_bus.ring_out_dbg  = r_out_dbg;
endmodule

// File: tb/tb_mby_tag_uc_ring_arb.sv
// Directed bench for mby_tag_uc_ring_arb (N_REQ=4, STARVE_LIMIT=8); expected ring output
// slots are queued when stimulus is driven and compared one cycle later.
module tb_mby_tag_uc_ring_arb;
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = 32;

    logic clk;
    logic rst;

    mby_tag_uc_ring_arb_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    mby_tag_uc_ring_arb #(
        .N_REQ       (N_REQ),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_err;
    logic [33:0] exp_q[$];      // {val, dbg, data}
    logic [31:0] last_data;
    logic [31:0] tags[N_REQ];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One cycle: drive, check combinational grant/stall, queue the expected slot, then
    // compare the registered output after the edge.
    task automatic step(input string name, input logic cfg, input logic rin_val,
                        input logic [31:0] rin_data, input logic [3:0] rq,
                        input int exp_g, input logic exp_pass, input logic exp_stall);
        logic [3:0]  exp_rdy;
        logic [33:0] e;
        logic [33:0] got;
        bus.cfg_en       = cfg;
        bus.ring_in_val  = rin_val;
        bus.ring_in_data = rin_data;
        bus.req_val      = rq;
        #2;
        exp_rdy = (exp_g >= 0) ? (4'b0001 << exp_g) : 4'b0000;
        check({name, ".rdy"}, 64'(bus.req_rdy), 64'(exp_rdy));
        check({name, ".stall"}, 64'(bus.ring_in_stall), 64'(exp_stall));
        if (exp_g >= 0) begin
            e = {1'b1, 1'b1, tags[exp_g]};
        end else if (exp_pass) begin
            e = {1'b1, 1'b0, rin_data};
        end else begin
            e = {1'b0, 1'b0, last_data};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        got = {bus.ring_out_val, bus.ring_out_dbg, bus.ring_out_data};
        check({name, ".out"}, 64'(got), 64'(e));
        if (e[33]) last_data = e[31:0];
    endtask

    task automatic reset_cycle(input string name);
        rst = 1'b1;
        #2;
        check({name, ".rdy"}, 64'(bus.req_rdy), 64'd0);
        check({name, ".stall"}, 64'(bus.ring_in_stall), 64'd0);
        @(posedge clk);
        #1;
        check({name, ".out"}, 64'({bus.ring_out_val, bus.ring_out_dbg, bus.ring_out_data}),
              64'd0);
        last_data = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < N_REQ; i++) begin
            tags[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
            bus.req_data[i*DATA_W +: DATA_W] = tags[i];
        end
        rst              = 1'b1;
        bus.cfg_en       = 1'b1;
        bus.ring_in_val  = 1'b1;
        bus.ring_in_data = 32'hFFFF_FFFF;
        bus.req_val      = 4'b1111;
        last_data        = '0;

        // Reset with every input active.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst.rdy", 64'(bus.req_rdy), 64'd0);
            check("rst.stall", 64'(bus.ring_in_stall), 64'd0);
            check("rst.out", 64'({bus.ring_out_val, bus.ring_out_dbg, bus.ring_out_data}),
                  64'd0);
        end
        rst = 1'b0;

        // Round-robin over all requesters with the ring idle.
        for (int i = 0; i < 8; i++) begin
            step("rr", 1'b1, 1'b0, 32'h0, 4'b1111, i % 4, 1'b0, 1'b0);
        end

        // Ring traffic wins, then req 2 on the idle slot.
        step("pass", 1'b1, 1'b1, 32'h0000_00A5, 4'b0100, -1, 1'b1, 1'b0);
        step("pass_idle", 1'b1, 1'b0, 32'h0, 4'b0100, 2, 1'b0, 1'b0);

        // rr_ptr=3: skip and wrap to req 0, then req 1.
        step("wrap0", 1'b1, 1'b0, 32'h0, 4'b0011, 0, 1'b0, 1'b0);
        step("wrap1", 1'b1, 1'b0, 32'h0, 4'b0011, 1, 1'b0, 1'b0);
        step("adv2", 1'b1, 1'b0, 32'h0, 4'b0100, 2, 1'b0, 1'b0);
        step("adv3", 1'b1, 1'b0, 32'h0, 4'b1000, 3, 1'b0, 1'b0);

        // Insertion disabled: idle slot, data holds; ring still passes.
        step("cfg_off", 1'b0, 1'b0, 32'h0, 4'b1111, -1, 1'b0, 1'b0);
        step("cfg_off_pass", 1'b0, 1'b1, 32'h0000_003C, 4'b1111, -1, 1'b1, 1'b0);
        step("cfg_on", 1'b1, 1'b0, 32'h0, 4'b1111, 0, 1'b0, 1'b0);

        // Withdrawn requests are not granted.
        step("withdraw", 1'b1, 1'b0, 32'h0, 4'b0000, -1, 1'b0, 1'b0);

        // Reset mid-operation drops the slot and restarts the pointer.
        step("pre_rst", 1'b1, 1'b0, 32'h0, 4'b1111, 1, 1'b0, 1'b0);
        reset_cycle("mid_rst");
        rst = 1'b0;
        step("post_rst", 1'b1, 1'b0, 32'h0, 4'b1111, 0, 1'b0, 1'b0);

`ifdef MBY_TAG_UC_ARB_ANTISTARVE_EN
        for (int i = 0; i < 8; i++) begin
            step("starve", 1'b1, 1'b1, 32'h0000_005A, 4'b0001, -1, 1'b1, 1'b0);
        end
        step("force", 1'b1, 1'b1, 32'h0000_005A, 4'b0001, 0, 1'b0, 1'b1);
        step("held_fwd", 1'b1, 1'b1, 32'h0000_005A, 4'b0001, -1, 1'b1, 1'b0);
        step("starve_end", 1'b1, 1'b0, 32'h0, 4'b0001, 0, 1'b0, 1'b0);
        // Requests vanish while forcing: stall without a grant.
        for (int i = 0; i < 8; i++) begin
            step("starve2", 1'b1, 1'b1, 32'h0000_0077, 4'b0001, -1, 1'b1, 1'b0);
        end
        step("force_empty", 1'b1, 1'b1, 32'h0000_0077, 4'b0000, -1, 1'b0, 1'b1);
        step("force_empty_fwd", 1'b1, 1'b1, 32'h0000_0077, 4'b0000, -1, 1'b1, 1'b0);
`else
        for (int i = 0; i < 100; i++) begin
            step("starve", 1'b1, 1'b1, 32'h0000_005A, 4'b0001, -1, 1'b1, 1'b0);
        end
        step("starve_end", 1'b1, 1'b0, 32'h0, 4'b0001, 0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
